// File: rtl/ramp_pkg.sv
// Shared definitions for the ramp pattern path: sample width, checker FSM
// state encoding and modulo-2^RAMP_DW arithmetic helpers.
package ramp_pkg;

  localparam int RAMP_DW = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    TRAIN  = 2'd2,
    LOCKED = 2'd3
  } ramp_state_e;

  // Wrapping add; the carry out of the top bit is dropped.
  function automatic logic [RAMP_DW-1:0] mod_add(input logic [RAMP_DW-1:0] a,
                                                 input logic [RAMP_DW-1:0] b);
    return a + b;
  endfunction

  // Wrapping subtract; a borrow out of the top bit is dropped.
  function automatic logic [RAMP_DW-1:0] mod_sub(input logic [RAMP_DW-1:0] a,
                                                 input logic [RAMP_DW-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Holds at all-ones once
// reached; clear takes priority over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ramp_checker.sv
// Receive-side ramp pattern checker. Learns the step from the first two valid
// samples, then checks each valid sample against prev+step (mod 2^DW).
// Optional macro RAMP_CHK_RESYNC_EN: on a mismatch re-align to the received
// sample instead of the expected one.
module ramp_checker
  import ramp_pkg::*;
#(
  parameter int DW       = RAMP_DW,
  parameter int LOSS_THR = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chk_enb,
  input  logic [DW-1:0]    din,
  input  logic             din_vld,
  output logic             locked,
  output logic [DW-1:0]    step,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state_o
);

  // miss_run only ever counts up to LOSS_THR before being cleared.
  localparam int MISS_W = $clog2(LOSS_THR + 1);

  ramp_state_e       state_q, state_d;
  logic [DW-1:0]     prev_q, prev_d;
  logic [DW-1:0]     step_q, step_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [MISS_W-1:0] miss_inc;
  logic [DW-1:0]     exp_val;

  assign exp_val  = mod_add(prev_q, step_q);
  assign miss_inc = miss_q + 1'b1;

  // Next-state and datapath decode; a low enable overrides every state.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    step_d   = step_q;
    locked_d = locked_q;
    miss_d   = miss_q;
    err_d    = 1'b0;
    if (!chk_enb) begin
      state_d  = IDLE;
      locked_d = 1'b0;
      miss_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A sample arriving with the enable edge is deliberately dropped.
          state_d = ACQ;
        end
        ACQ: begin
          if (din_vld) begin
            prev_d  = din;
            state_d = TRAIN;
          end
        end
        TRAIN: begin
          if (din_vld) begin
            step_d   = mod_sub(din, prev_q);
            prev_d   = din;
            locked_d = 1'b1;
            miss_d   = '0;
            state_d  = LOCKED;
          end
        end
        LOCKED: begin
          if (din_vld) begin
            if (din == exp_val) begin
              miss_d = '0;
              prev_d = din;
            end else begin
              err_d = 1'b1;
`ifdef RAMP_CHK_RESYNC_EN
              prev_d = din;
`else
              prev_d = exp_val;
`endif
              if (miss_inc == MISS_W'(LOSS_THR)) begin
                locked_d = 1'b0;
                miss_d   = '0;
                state_d  = ACQ;
              end else begin
                miss_d = miss_inc;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      step_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      step_q   <= step_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      miss_q   <= miss_d;
    end
  end

  // Error count survives loss of lock; only disable or reset clears it.
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!chk_enb),
    .inc  (err_d),
    .cnt  (err_cnt)
  );

  assign locked  = locked_q;
  assign step    = step_q;
  assign err     = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_ramp_checker.sv
// Directed bench for ramp_checker: lock, wrap, glitch, loss/relock, gaps,
// enable drop and asynchronous reset. Expectations follow RAMP_CHK_RESYNC_EN.
module tb_ramp_checker;

  logic        clk;
  logic        rst_n;
  logic        chk_enb;
  logic [11:0] din;
  logic        din_vld;
  logic        locked;
  logic [11:0] step;
  logic        err;
  logic [15:0] err_cnt;
  logic [1:0]  state_o;

  int nvec = 0;
  int nmis = 0;

  ramp_checker #(
    .DW(12),
    .LOSS_THR(3),
    .CNT_W(16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .chk_enb(chk_enb),
    .din    (din),
    .din_vld(din_vld),
    .locked (locked),
    .step   (step),
    .err    (err),
    .err_cnt(err_cnt),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic sample(input logic [11:0] d);
    din     = d;
    din_vld = 1'b1;
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    chk_enb = 1'b0;
    din_vld = 1'b0;
    din     = 12'h000;
    tick();
    tick();
    check("rst_state", state_o, 0);
    check("rst_locked", locked, 0);
    check("rst_step", step, 0);
    check("rst_err", err, 0);
    check("rst_cnt", err_cnt, 0);
    rst_n = 1'b1;

    // Lock on step 3
    chk_enb = 1'b1;
    tick();
    check("lock_acq", state_o, 1);
    sample(12'h000);
    check("lock_train", state_o, 2);
    check("lock_notyet", locked, 0);
    sample(12'h003);
    check("lock_locked", locked, 1);
    check("lock_step", step, 12'h003);
    sample(12'h006);
    check("lock_err6", err, 0);
    sample(12'h009);
    check("lock_err9", err, 0);
    check("lock_cnt", err_cnt, 0);

    // Wrap-around with step 2; sample on the enable edge must be ignored
    din_vld = 1'b0;
    chk_enb = 1'b0;
    tick();
    check("wrap_idle", state_o, 0);
    chk_enb = 1'b1;
    sample(12'hFFA);
    check("wrap_ignore", state_o, 1);
    sample(12'hFFC);
    check("wrap_train", state_o, 2);
    sample(12'hFFE);
    check("wrap_step", step, 12'h002);
    sample(12'h000);
    check("wrap_err0", err, 0);
    sample(12'h002);
    check("wrap_err2", err, 0);
    check("wrap_cnt", err_cnt, 0);

    // Single glitch on step 1
    din_vld = 1'b0;
    chk_enb = 1'b0;
    tick();
    chk_enb = 1'b1;
    tick();
    sample(12'h010);
    sample(12'h011);
    check("gl_step", step, 12'h001);
    sample(12'h055);
    check("gl_err", err, 1);
    check("gl_cnt1", err_cnt, 1);
    sample(12'h013);
`ifdef RAMP_CHK_RESYNC_EN
    check("gl_err_next", err, 1);
    check("gl_cnt2", err_cnt, 2);
`else
    check("gl_err_next", err, 0);
    check("gl_cnt2", err_cnt, 1);
`endif
    check("gl_locked", locked, 1);
    sample(12'h014);
    check("gl_err_after", err, 0);

    // One-cycle disable with a bad valid sample: no err, everything cleared
    chk_enb = 1'b0;
    sample(12'h777);
    check("dis_state", state_o, 0);
    check("dis_cnt", err_cnt, 0);
    check("dis_locked", locked, 0);
    check("dis_err", err, 0);
    chk_enb = 1'b1;
    din_vld = 1'b0;
    tick();

    // Loss of lock after three consecutive misses, then relock on step 5
    sample(12'h020);
    sample(12'h024);
    check("loss_step", step, 12'h004);
    sample(12'h028);
    check("loss_good", err, 0);
    sample(12'h100);
    check("loss_m1_err", err, 1);
    check("loss_m1_lock", locked, 1);
    sample(12'h200);
    check("loss_m2_cnt", err_cnt, 2);
    check("loss_m2_state", state_o, 3);
    sample(12'h300);
    check("loss_m3_err", err, 1);
    check("loss_m3_cnt", err_cnt, 3);
    check("loss_m3_lock", locked, 0);
    check("loss_m3_state", state_o, 1);
    sample(12'h400);
    check("relock_train", state_o, 2);
    check("relock_err", err, 0);
    sample(12'h405);
    check("relock_lock", locked, 1);
    check("relock_step", step, 12'h005);
    check("relock_cnt", err_cnt, 3);

    // Five-cycle gap mid-lock
    din_vld = 1'b0;
    din     = 12'hABC;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gap_state", state_o, 3);
      check("gap_err", err, 0);
    end
    sample(12'h40A);
    check("gap_resume", err, 0);
    check("gap_cnt", err_cnt, 3);

    // Build err_cnt to 5 without losing lock
    sample(12'h000);
    check("pre_rst_err", err, 1);
    sample(12'h999);
    check("pre_rst_cnt", err_cnt, 5);
    check("pre_rst_lock", locked, 1);
    din_vld = 1'b0;

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", state_o, 0);
    check("arst_locked", locked, 0);
    check("arst_step", step, 0);
    check("arst_err", err, 0);
    check("arst_cnt", err_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/ramp_checker.md
Name: ramp_checker

Overview:
- Receive-side checker for the 12-bit ramp pattern output.
- Sits downstream of the ramp generator on the sample bus and learns the ramp step from the first two valid samples.
- Then verifies every subsequent sample against the expected next value (modulo 2^DW), reporting lock, per-sample errors and a saturating error count.
- Used in loopback self-test of the pattern path.

Parameters:
DW, 12, sample width (matches generator output)
LOSS_THR, 3, consecutive mismatches that drop lock
CNT_W, 16, width of error counter

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
chk_enb  input  1  checker enable; low forces IDLE
din  input  DW  sample under test
din_vld  input  1  din valid this cycle
locked  output  1  ramp lock acquired
step  output  DW  learned step (din[n]-din[n-1] mod 2^DW)
err  output  1  one-cycle pulse: mismatching valid sample while LOCKED
err_cnt  output  CNT_W  total mismatches since enable, saturates at all-ones
state_o  output  2  current FSM state encoding (debug)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; locked=0, step=0, err=0, err_cnt=0; internal prev=0, miss_run=0. Deassertion takes effect on the next clk edge.
- All outputs are registered; response to a sample on cycle n is visible after edge n+1 (latency 1).
- States: IDLE=0, ACQ=1, TRAIN=2, LOCKED=3.
- IDLE:
  - While chk_enb=0: hold IDLE, clear err_cnt, miss_run and locked.
  - chk_enb=1 -> ACQ.
- ACQ:
  - On din_vld: prev<=din -> TRAIN.
  - No valid sample: stay.
- TRAIN:
  - On din_vld: step<=din-prev (DW-bit wrap), prev<=din -> LOCKED, locked<=1.
  - A computed step of 0 is legal (flat pattern).
- LOCKED: on din_vld, exp=prev+step (DW-bit wrap, e.g. 0xFFF+0x002=0x001).
  - Match: miss_run<=0, prev<=din.
  - Mismatch: err pulses, err_cnt+1 (saturating), miss_run+1, prev<=exp (see feature).
  - If miss_run reaches LOSS_THR: locked<=0, state<=ACQ, miss_run<=0.
- din_vld=0 in any state: no state change, no err, prev held.
- chk_enb falling in any state: next edge -> IDLE, locked=0. err is not asserted on that edge, even if din_vld.
- Simultaneous chk_enb rise and din_vld in IDLE: the sample is ignored; ACQ starts the next cycle.
- err_cnt is not cleared on loss of lock, only by IDLE or reset.

Optional Feature:
- Macro RAMP_CHK_RESYNC_EN.
- Defined: on mismatch in LOCKED, prev<=din, so the checker re-aligns to the received phase. A single glitch then produces 2 errors (glitch plus the following sample).
- Undefined (default): prev<=exp, so an isolated corrupted sample produces exactly 1 error.

Decomposition:
- Shared package ramp_pkg holds:
  - the RAMP_DW=12 constant, shared with the generator;
  - the state enum typedef (IDLE/ACQ/TRAIN/LOCKED);
  - the modular add/sub helper functions.
- One sub-module, sat_counter (parameter CNT_W; inputs inc, clr), used for err_cnt.
- The FSM and compare logic stay in ramp_checker.

Test Plan:
- Lock: rst_n low 2 cycles, chk_enb=1, din_vld=1, din=0x000,0x003,0x006,0x009 -> locked=1 after second sample edge, step=0x003, err never high, err_cnt=0.
- Wrap-around: step 0x002 with samples 0xFFC,0xFFE,0x000,0x002 -> no err; exp wraps correctly.
- Single glitch: locked on step 1 at 0x010,0x011, then 0x055, then 0x013 -> exactly one err pulse, err_cnt=1, locked stays 1. With RAMP_CHK_RESYNC_EN: 2 pulses, err_cnt=2.
- Loss of lock: LOSS_THR=3, three consecutive bad samples -> err_cnt=3, locked=0, state_o=ACQ. Next two good samples relock with the new step.
- Gaps and enable: din_vld low 5 cycles mid-lock -> no state change. chk_enb=0 for 1 cycle -> state_o=0, err_cnt=0, locked=0.
- Async reset mid-LOCKED with err_cnt=5: rst_n low between edges -> all outputs 0 immediately, without waiting for clk.
